lfsr_checker: RTL
=================

// Module: lfsr_checker
// PURPOSE
//  Receive-side checker for the 4-bit XNOR LFSR pattern (next = {s[2:0], ~(s[3]^s[2])}).
//  Seeds from incoming samples, acquires lock after consecutive correct predictions,
//  then free-runs its own reference and counts mismatches. Sits between a sampled
//  pattern input (loopback / GPIO) and the LED/debug logic; flags link integrity.
// PARAMETERS
//  DATA_WIDTH    4   sample width; taps fixed at bits TAP_A/TAP_B
//  TAP_A         3   first feedback tap index
//  TAP_B         2   second feedback tap index
//  LOCK_COUNT    4   consecutive matches needed to enter LOCKED (>=1)
//  UNLOCK_COUNT  3   consecutive mismatches in LOCKED that drop lock (>=1)
//  ERR_WIDTH     16  width of saturating error counter
// PORTS
//  clk        in   1           system clock, all logic posedge
//  rst_n      in   1           asynchronous reset, active-low
//  in_valid   in   1           in_data holds a new sample this cycle
//  in_data    in   DATA_WIDTH  received pattern sample
//  clear_err  in   1           synchronous clear of err_count
//  locked     out  1           checker is in LOCKED state
//  err_pulse  out  1           one-cycle pulse per mismatch while LOCKED
//  err_count  out  ERR_WIDTH   saturating mismatch count (LOCKED only)
//  stuck      out  1           sticky all-ones lockup flag (LFSR_CHK_STUCK_DETECT_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=SEEK, ref=0, match_cnt=0, miss_cnt=0,
//    locked=0, err_pulse=0, err_count=0, stuck=0. rst_n low mid-lock drops locked immediately.
//  - nxt(x) = {x[W-2:0], ~(x[TAP_A]^x[TAP_B])}. All outputs registered; latency 1 clk
//    from the in_valid cycle. in_valid=0: no state/counter change, err_pulse=0.
//  - SEEK: on in_valid: ref<=in_data, match_cnt<=0 -> ACQUIRE.
//  - ACQUIRE: on in_valid: ref<=in_data always.
//    in_data==nxt(ref): match_cnt++; if match_cnt==LOCK_COUNT-1 -> LOCKED, locked<=1.
//    else: match_cnt<=0, stay ACQUIRE. No errors counted in ACQUIRE.
//  - LOCKED: on in_valid: ref<=nxt(ref) (free-run, input never re-seeds).
//    match: miss_cnt<=0. mismatch: err_pulse<=1, err_count++ (saturate at all-ones),
//    miss_cnt++; if miss_cnt==UNLOCK_COUNT-1 -> ACQUIRE, ref<=in_data, match_cnt<=0,
//    locked<=0 (the unlocking mismatch is still counted).
//  - clear_err and an increment in the same cycle: err_count<=1. clear_err alone: 0.
//    clear_err also clears stuck (when compiled in).
//  - Counters match_cnt/miss_cnt sized $clog2(max(LOCK_COUNT,UNLOCK_COUNT))+1; no wrap.
// CONFIGURATION
//  LFSR_CHK_STUCK_DETECT_EN defined: all-ones (nxt(all-ones)==all-ones lockup) in_data
//    in SEEK/ACQUIRE sets stuck<=1 (sticky), never seeds ref, forces match_cnt<=0
//    and state ACQUIRE; in LOCKED an all-ones sample is always a mismatch.
//  Not defined: stuck tied 0; all-ones treated as ordinary data (checker can lock on it).
// TESTING
//  1 reset, feed 0,1,3,7,E (one in_valid each) -> locked=1 cycle after sample E, err_count=0.
//  2 locked after test 1, feed 5 (expect D) then B -> one err_pulse, err_count=1, locked stays 1.
//  3 locked, feed three wrong samples -> err_count=3, locked=0 after 3rd; resume seq -> relock after 4 matches.
//  4 ERR_WIDTH=2, UNLOCK_COUNT=8, locked, 5 mismatches -> err_count=3 (saturated); clear_err+mismatch same cycle -> 1.
//  5 locked, drop rst_n between clock edges -> locked/err_count=0 without clock edge; state SEEK.
//  6 feed F x6: macro undefined -> locked=1, stuck=0; macro defined -> stuck=1, locked=0; clear_err -> stuck=0.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for a 4-bit XNOR LFSR pattern: seeds, locks, then counts mismatches.
// Optional all-ones lockup detection is compiled in with LFSR_CHK_STUCK_DETECT_EN.
module lfsr_checker #(
  parameter int DATA_WIDTH   = 4,
  parameter int TAP_A        = 3,
  parameter int TAP_B        = 2,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  clear_err,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  stuck
);

  localparam int MaxCount = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CW       = $clog2(MaxCount) + 1;

  localparam logic [1:0] S_SEEK    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  function automatic logic [DATA_WIDTH-1:0] nxt(input logic [DATA_WIDTH-1:0] x);
    return {x[DATA_WIDTH-2:0], ~(x[TAP_A] ^ x[TAP_B])};
  endfunction

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] ref_q, ref_d;
  logic [CW-1:0]         match_q, match_d;
  logic [CW-1:0]         miss_q, miss_d;
  logic                  locked_q, locked_d;
  logic                  pulse_q, pulse_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [DATA_WIDTH-1:0] expected;
  logic                  allOnes;
  logic                  mismatch;
  logic                  errInc;

  assign expected = nxt(ref_q);

`ifdef LFSR_CHK_STUCK_DETECT_EN
  // All-ones maps onto itself, so it can never be a legitimate seed.
  assign allOnes = &in_data;
`else
  assign allOnes = 1'b0;
`endif

  assign mismatch = (in_data != expected) || allOnes;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    errInc   = 1'b0;
    if (in_valid) begin
      case (state_q)
        S_SEEK: begin
          match_d = '0;
          state_d = S_ACQUIRE;
          if (!allOnes) ref_d = in_data;
        end
        S_ACQUIRE: begin
          if (allOnes) begin
            match_d = '0;
          end else begin
            ref_d = in_data;
            if (in_data == expected) begin
              match_d = match_q + CW'(1);
              if (match_q == CW'(LOCK_COUNT - 1)) begin
                state_d  = S_LOCKED;
                locked_d = 1'b1;
                miss_d   = '0;
              end
            end else begin
              match_d = '0;
            end
          end
        end
        S_LOCKED: begin
          // Once locked the reference free-runs; the input never re-seeds it.
          ref_d = expected;
          if (mismatch) begin
            pulse_d = 1'b1;
            errInc  = 1'b1;
            miss_d  = miss_q + CW'(1);
            if (miss_q == CW'(UNLOCK_COUNT - 1)) begin
              state_d  = S_ACQUIRE;
              ref_d    = in_data;
              match_d  = '0;
              miss_d   = '0;
              locked_d = 1'b0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d  = S_SEEK;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (clear_err) begin
      err_d = errInc ? ERR_WIDTH'(1) : '0;
    end else if (errInc && !(&err_q)) begin
      err_d = err_q + ERR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_SEEK;
      ref_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

`ifdef LFSR_CHK_STUCK_DETECT_EN
  logic stuck_q;
  logic stuckSet;

  // A lockup sample seen while seeding sets the sticky flag, even in the clearing cycle.
  assign stuckSet = in_valid && allOnes && (state_q != S_LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q <= 1'b0;
    end else begin
      stuck_q <= (stuck_q && !clear_err) || stuckSet;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = err_q;

endmodule
